// File: rtl/decoder_scan_n.sv
// -----------------------------------------------------------------------------
// decoder_scan_n
//   SEL_W-to-2**SEL_W one-hot decoder with registered outputs, an enable and
//   two operating modes.
//
//   DIRECT mode: out is 1<<sel, one clock after sel is applied.
//   SCAN mode:   an internal index starts at sel. It then steps through every
//                output, and each output is held for DWELL cycles.
//
//   Typical use: digit/row strobes for multiplexed LED and 7-seg displays.
//
// Parameters
//   SEL_W  select width; the output width is 2**SEL_W
//   DWELL  cycles each output is held in SCAN mode (>= 1)
//
// Ports
//   clk     in   1        rising-edge clock
//   reset   in   1        asynchronous, active-high reset
//   enable  in   1        1 = decoder active, 0 = all outputs low
//   mode    in   1        0 = DIRECT, 1 = SCAN
//   sel     in   SEL_W    DIRECT: decoded index; SCAN: start index (entry only)
//   out     out  2**SEL_W registered one-hot strobe, zero when idle
//   cur     out  SEL_W    registered index currently asserted on out
//   wrap    out  1        one-cycle pulse when the scan index wraps to 0
// -----------------------------------------------------------------------------
module decoder_scan_n #(
    parameter int SEL_W = 4,
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   out,
    output logic [SEL_W-1:0]      cur,
    output logic                  wrap
);

    localparam int OUT_W = 2**SEL_W;
    // The dwell counter still exists when DWELL=1, but it always holds 0.
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [SEL_W-1:0]   cur_q, cur_d;
    logic               wrap_q, wrap_d;
    logic [DW-1:0]      dwell_q, dwell_d;
    logic [SEL_W-1:0]   cur_inc;

    assign cur_inc = cur_q + SEL_W'(1);

    always_comb begin
        // Next state depends only on enable and mode. The outputs are then
        // computed for the state being entered, so every output is registered.
        state_d = ST_IDLE;
        out_d   = out_q;
        cur_d   = cur_q;
        wrap_d  = 1'b0;
        dwell_d = dwell_q;

        if (!enable) begin
            state_d = ST_IDLE;
        end else if (!mode) begin
            state_d = ST_DIRECT;
        end else begin
            state_d = ST_SCAN;
        end

        case (state_d)
            ST_DIRECT: begin
                out_d   = OUT_W'(1) << sel;
                cur_d   = sel;
                dwell_d = '0;
            end
            ST_SCAN: begin
                if (state_q != ST_SCAN) begin
                    // A fresh entry always starts at sel and holds it for a full
                    // DWELL. Any earlier scan position is discarded.
                    out_d   = OUT_W'(1) << sel;
                    cur_d   = sel;
                    dwell_d = '0;
                end else if (dwell_q == DWELL_LAST) begin
                    out_d   = OUT_W'(1) << cur_inc;
                    cur_d   = cur_inc;
                    dwell_d = '0;
                    wrap_d  = &cur_q;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: begin
                // Idle: strobes off. cur keeps its last value.
                out_d   = '0;
                dwell_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            cur_q   <= '0;
            wrap_q  <= 1'b0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cur_q   <= cur_d;
            wrap_q  <= wrap_d;
            dwell_q <= dwell_d;
        end
    end

    assign out  = out_q;
    assign cur  = cur_q;
    assign wrap = wrap_q;

endmodule
